// File: rtl/timer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : timer_pkg
// Description : Shared types and constants for the countdown timer core.
// Revision    : 1.0 - initial release
// ============================================================================
package timer_pkg;

    localparam int FIELD_W    = 8;
    localparam int MAX_HR_DEF = 23;
    localparam int MAX_MS_DEF = 59;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RUN     = 2'd1,
        ST_PAUSE   = 2'd2,
        ST_EXPIRED = 2'd3
    } state_t;

    function automatic logic [FIELD_W-1:0] clamp(input logic [FIELD_W-1:0] v,
                                                 input logic [FIELD_W-1:0] mx);
        return (v > mx) ? mx : v;
    endfunction

endpackage
`default_nettype wire

// File: rtl/cnt_down_mod.sv
`default_nettype none
// ============================================================================
// Module      : cnt_down_mod
// Description : One down-counting time field; reloads MAX_VAL on borrow.
// Revision    : 1.0 - initial release
// ============================================================================
module cnt_down_mod
    import timer_pkg::*;
#(
    parameter int MAX_VAL = MAX_MS_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               ld,
    input  logic [FIELD_W-1:0] ld_val,
    input  logic               en,
    input  logic               borrow_in,
    output logic [FIELD_W-1:0] val,
    output logic               borrow_out,
    output logic               is_zero
);

    localparam logic [FIELD_W-1:0] c_max = FIELD_W'(MAX_VAL);

    logic [FIELD_W-1:0] r_val;

    assign val        = r_val;
    assign is_zero    = (r_val == '0);
    // Borrow ripples upward purely from the current value, independent of en.
    assign borrow_out = borrow_in & is_zero;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_val <= '0;
        end else if (ld) begin
            r_val <= ld_val;
        end else if (en && borrow_in) begin
            r_val <= is_zero ? c_max : r_val - 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/countdown_timer_core.sv
`default_nettype none
// ============================================================================
// Module      : countdown_timer_core
// Description : HH:MM:SS countdown with load clamp, pause/resume and alarm.
// Revision    : 1.0 - initial release
// ============================================================================
module countdown_timer_core
    import timer_pkg::*;
#(
    parameter int MAX_HR = MAX_HR_DEF,
    parameter int MAX_MS = MAX_MS_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               tick,
    input  logic               load,
    input  logic               start,
    input  logic               stop,
    input  logic               ack,
    input  logic [FIELD_W-1:0] hr_set,
    input  logic [FIELD_W-1:0] min_set,
    input  logic [FIELD_W-1:0] sec_set,
    output logic [FIELD_W-1:0] hr,
    output logic [FIELD_W-1:0] min,
    output logic [FIELD_W-1:0] sec,
    output logic               running,
    output logic               done
);

    localparam logic [FIELD_W-1:0] c_max_hr = FIELD_W'(MAX_HR);
    localparam logic [FIELD_W-1:0] c_max_ms = FIELD_W'(MAX_MS);

    state_t r_state;
    logic   r_running;
    logic   r_done;

    logic w_capture;
    logic w_dec;
    logic w_dec_en;
    logic w_sec_borrow, w_min_borrow, w_hr_borrow;
    logic w_sec_zero, w_min_zero, w_hr_zero;
    logic w_at_zero;
    logic w_last_sec;

    assign w_capture  = load && (r_state != ST_RUN);
    assign w_dec      = (r_state == ST_RUN) && !stop && tick;
    // hr borrow_out means the whole count is zero; never let it wrap.
    assign w_dec_en   = w_dec && !w_hr_borrow;
    assign w_at_zero  = w_sec_zero && w_min_zero && w_hr_zero;
    assign w_last_sec = w_hr_zero && w_min_zero && (sec == FIELD_W'(1));

    cnt_down_mod #(.MAX_VAL(MAX_MS)) u_sec (
        .clk        (clk),
        .rst        (rst),
        .ld         (w_capture),
        .ld_val     (clamp(sec_set, c_max_ms)),
        .en         (w_dec_en),
        .borrow_in  (1'b1),
        .val        (sec),
        .borrow_out (w_sec_borrow),
        .is_zero    (w_sec_zero)
    );

    cnt_down_mod #(.MAX_VAL(MAX_MS)) u_min (
        .clk        (clk),
        .rst        (rst),
        .ld         (w_capture),
        .ld_val     (clamp(min_set, c_max_ms)),
        .en         (w_dec_en),
        .borrow_in  (w_sec_borrow),
        .val        (min),
        .borrow_out (w_min_borrow),
        .is_zero    (w_min_zero)
    );

    cnt_down_mod #(.MAX_VAL(MAX_HR)) u_hr (
        .clk        (clk),
        .rst        (rst),
        .ld         (w_capture),
        .ld_val     (clamp(hr_set, c_max_hr)),
        .en         (w_dec_en),
        .borrow_in  (w_min_borrow),
        .val        (hr),
        .borrow_out (w_hr_borrow),
        .is_zero    (w_hr_zero)
    );

    assign running = r_running;
    assign done    = r_done;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= ST_IDLE;
            r_running <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (!load && start && !w_at_zero) begin
                        r_state   <= ST_RUN;
                        r_running <= 1'b1;
                    end
                end
                ST_RUN: begin
                    if (stop) begin
                        r_state   <= ST_PAUSE;
                        r_running <= 1'b0;
                    end else if (tick && w_last_sec) begin
                        // Alarm rises on the same edge the count lands on zero.
                        r_state   <= ST_EXPIRED;
                        r_running <= 1'b0;
                        r_done    <= 1'b1;
                    end
                end
                ST_PAUSE: begin
                    if (load) begin
                        r_state <= ST_IDLE;
                    end else if (start && !w_at_zero) begin
                        r_state   <= ST_RUN;
                        r_running <= 1'b1;
                    end
                end
                ST_EXPIRED: begin
                    if (load || ack) begin
                        r_state <= ST_IDLE;
                        r_done  <= 1'b0;
                    end
                end
                default: begin
                    r_state   <= ST_IDLE;
                    r_running <= 1'b0;
                    r_done    <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_countdown_timer_core.sv
`default_nettype none
// ============================================================================
// Module      : tb_countdown_timer_core
// Description : Directed and random stimulus against a seconds-total model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_countdown_timer_core;

    localparam int M_IDLE    = 0;
    localparam int M_RUN     = 1;
    localparam int M_PAUSE   = 2;
    localparam int M_EXPIRED = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       tick = 1'b0, load = 1'b0, start = 1'b0, stop = 1'b0, ack = 1'b0;
    logic [7:0] hr_set = '0, min_set = '0, sec_set = '0;
    logic [7:0] hr, min, sec;
    logic       running, done;

    int n_checks = 0;
    int n_errors = 0;

    // Model: remaining time kept as a single seconds total.
    int m_total = 0;
    int m_state = M_IDLE;
    int m_done  = 0;

    countdown_timer_core dut (
        .clk     (clk),
        .rst     (rst),
        .tick    (tick),
        .load    (load),
        .start   (start),
        .stop    (stop),
        .ack     (ack),
        .hr_set  (hr_set),
        .min_set (min_set),
        .sec_set (sec_set),
        .hr      (hr),
        .min     (min),
        .sec     (sec),
        .running (running),
        .done    (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int clampi(input int v, input int mx);
        return (v > mx) ? mx : v;
    endfunction

    task automatic model_reset();
        m_total = 0;
        m_state = M_IDLE;
        m_done  = 0;
    endtask

    task automatic model_step(input bit l, input bit s, input bit st, input bit a,
                              input bit t, input int h, input int m, input int sc);
        int cap;
        cap = clampi(h, 23) * 3600 + clampi(m, 59) * 60 + clampi(sc, 59);
        case (m_state)
            M_IDLE: begin
                if (l) m_total = cap;
                else if (s && m_total != 0) m_state = M_RUN;
            end
            M_RUN: begin
                if (st) m_state = M_PAUSE;
                else if (t) begin
                    m_total = m_total - 1;
                    if (m_total == 0) begin
                        m_state = M_EXPIRED;
                        m_done  = 1;
                    end
                end
            end
            M_PAUSE: begin
                if (l) begin
                    m_total = cap;
                    m_state = M_IDLE;
                end else if (s && m_total != 0) m_state = M_RUN;
            end
            default: begin
                if (l) begin
                    m_total = cap;
                    m_state = M_IDLE;
                    m_done  = 0;
                end else if (a) begin
                    m_state = M_IDLE;
                    m_done  = 0;
                end
            end
        endcase
    endtask

    task automatic compare_all(input string tag);
        check({tag, "_hr"},  32'(hr),      32'(m_total / 3600));
        check({tag, "_min"}, 32'(min),     32'((m_total / 60) % 60));
        check({tag, "_sec"}, 32'(sec),     32'(m_total % 60));
        check({tag, "_run"}, 32'(running), 32'(m_state == M_RUN));
        check({tag, "_done"},32'(done),    32'(m_done));
    endtask

    task automatic step(input string tag, input bit l, input bit s, input bit st,
                        input bit a, input bit t, input int h, input int m, input int sc);
        @(negedge clk);
        load = l; start = s; stop = st; ack = a; tick = t;
        hr_set = 8'(h); min_set = 8'(m); sec_set = 8'(sc);
        @(posedge clk);
        model_step(l, s, st, a, t, h, m, sc);
        #1;
        compare_all(tag);
    endtask

    task automatic idle_tick(input string tag, input int n);
        for (int i = 0; i < n; i++) step(tag, 0, 0, 0, 0, 1, 0, 0, 0);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        compare_all("reset");
        @(negedge clk);
        rst = 1'b1;

        // 1: short countdown into alarm
        step("t1_load", 1, 0, 0, 0, 0, 0, 0, 3);
        step("t1_start", 0, 1, 0, 0, 0, 0, 0, 0);
        idle_tick("t1_tick", 3);
        check("t1_done_const", 32'(done), 32'd1);
        check("t1_run_const", 32'(running), 32'd0);
        step("t1_ack", 0, 0, 0, 1, 0, 0, 0, 0);

        // 2: hour and minute borrows
        step("t2_load", 1, 0, 0, 0, 0, 1, 0, 0);
        step("t2_start", 0, 1, 0, 0, 0, 0, 0, 0);
        idle_tick("t2_tick", 1);
        check("t2_min_const", 32'(min), 32'd59);
        step("t2_stop", 0, 0, 1, 0, 0, 0, 0, 0);
        step("t2_load2", 1, 0, 0, 0, 0, 0, 1, 0);
        step("t2_start2", 0, 1, 0, 0, 0, 0, 0, 0);
        idle_tick("t2_tick2", 1);
        check("t2_sec_const", 32'(sec), 32'd59);

        // 3: stop wins over tick, pause holds
        step("t3_stop0", 0, 0, 1, 0, 0, 0, 0, 0);
        step("t3_load", 1, 0, 0, 0, 0, 0, 0, 10);
        step("t3_start", 0, 1, 0, 0, 0, 0, 0, 0);
        idle_tick("t3_tick", 2);
        step("t3_stoptick", 0, 0, 1, 0, 1, 0, 0, 0);
        check("t3_sec_const", 32'(sec), 32'd8);
        idle_tick("t3_pause", 5);
        step("t3_resume", 0, 1, 0, 0, 0, 0, 0, 0);
        idle_tick("t3_tick2", 1);
        check("t3_sec7_const", 32'(sec), 32'd7);

        // 4: clamp and zero start
        step("t4_stop", 0, 0, 1, 0, 0, 0, 0, 0);
        step("t4_load", 1, 0, 0, 0, 0, 30, 75, 99);
        check("t4_hr_const", 32'(hr), 32'd23);
        step("t4_zero", 1, 0, 0, 0, 0, 0, 0, 0);
        step("t4_start", 0, 1, 0, 0, 1, 0, 0, 0);
        idle_tick("t4_idle", 2);

        // 5: ack, load ignored in RUN, load beats start
        step("t5_load", 1, 0, 0, 0, 0, 0, 0, 1);
        step("t5_start", 0, 1, 0, 0, 0, 0, 0, 0);
        idle_tick("t5_exp", 1);
        step("t5_ack", 0, 0, 0, 1, 0, 0, 0, 0);
        check("t5_done_const", 32'(done), 32'd0);
        step("t5_load2", 1, 0, 0, 0, 0, 0, 0, 9);
        step("t5_start2", 0, 1, 0, 0, 0, 0, 0, 0);
        step("t5_runload", 1, 0, 0, 0, 0, 0, 0, 5);
        check("t5_ign_const", 32'(sec), 32'd9);
        step("t5_stop", 0, 0, 1, 0, 0, 0, 0, 0);
        step("t5_toidle", 1, 0, 0, 0, 0, 0, 0, 4);
        step("t5_ldstart", 1, 1, 0, 0, 0, 0, 0, 6);
        check("t5_ls_run_const", 32'(running), 32'd0);
        idle_tick("t5_still", 2);

        // 6: asynchronous reset mid-run
        step("t6_start", 0, 1, 0, 0, 0, 0, 0, 0);
        idle_tick("t6_tick", 1);
        @(negedge clk);
        #2 rst = 1'b0;
        #1;
        model_reset();
        compare_all("t6_async");
        @(negedge clk);
        rst = 1'b1;
        idle_tick("t6_after", 3);

        // Random phase
        for (int i = 0; i < 3000; i++) begin
            int h, m, s;
            if ($urandom_range(0, 3) == 0) begin
                h = $urandom_range(0, 255);
                m = $urandom_range(0, 255);
                s = $urandom_range(0, 255);
            end else begin
                h = 0;
                m = $urandom_range(0, 1);
                s = $urandom_range(0, 5);
            end
            step("rnd", ($urandom_range(0, 11) == 0), ($urandom_range(0, 4) == 0),
                 ($urandom_range(0, 15) == 0), ($urandom_range(0, 5) == 0),
                 ($urandom_range(0, 1) == 0), h, m, s);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
